aurora_tx_frame_buffer: RTL and testbench

//  TX ingress stage ahead of data_controller: accepts user AXI4-Stream frames, buffers them in a FIFO
//  and drives data_controller's axi_valid/axi_last/axi_data, which has no backpressure of its own.

---
 rtl/aurora_tx_frame_buffer.sv | 142 ++++++++++++++
 tb/tb_aurora_tx_frame_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_tx_frame_buffer.sv
// aurora_tx_frame_buffer
// TX ingress buffer in front of data_controller. User AXI4-Stream words are
// queued as {last, data}. Whole frames are released (store-and-forward) once the
// link is up; a full FIFO falls back to cut-through so oversized frames still
// drain. Each released word is paced by tx_ready from the lane scheduler.
module aurora_tx_frame_buffer #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 16,
   localparam int LVL_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              channel_init_finished,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              tx_ready,
   output logic              axi_valid,
   output logic              axi_last,
   output logic [DATA_W-1:0] axi_data,
   output logic [LVL_W-1:0]  fill_level,
   output logic              underrun
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [DATA_W:0]     r_mem [DEPTH];
   logic [AW:0]         r_wr_ptr;
   logic [AW:0]         r_rd_ptr;
   logic [LVL_W-1:0]    r_fill;
   logic [LVL_W-1:0]    r_frame_cnt;
   logic                r_in_frame;

   logic                w_empty;
   logic                w_full;
   logic                w_run;
   logic                w_wr_en;
   logic                w_pop;
   logic [DATA_W:0]     w_rd_entry;
   logic                w_wr_last;
   logic                w_pop_last;

   // The extra pointer bit separates "same slot, empty" from "same slot, full".
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_run      = (r_state == ST_RUN);

   assign s_axis_tready = w_run && !w_full;
   assign w_wr_en       = s_axis_tvalid && s_axis_tready;

   // Release a word when a frame is in flight, a complete frame is queued, or
   // the FIFO is full (cut-through so an over-long frame cannot deadlock).
   assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
   assign w_pop      = w_run && tx_ready && !w_empty &&
                       (r_in_frame || (r_frame_cnt != '0) || w_full);
   assign w_wr_last  = w_wr_en && s_axis_tlast;
   assign w_pop_last = w_pop && w_rd_entry[DATA_W];

   assign fill_level = r_fill;

   // Link state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Link state transitions: FLUSH lasts exactly one cycle and discards the queue.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_INIT:  if (channel_init_finished)  w_state_next = ST_RUN;
         ST_RUN:   if (!channel_init_finished) w_state_next = ST_FLUSH;
         ST_FLUSH: w_state_next = ST_INIT;
         default:  w_state_next = ST_INIT;
      endcase
   end

   // Storage array; no reset so it maps onto RAM, pointers define validity.
   always_ff @(posedge clk) begin
      if (w_wr_en && !rst) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   // Pointers, fill level, complete-frame count and in-frame tracking.
   always_ff @(posedge clk) begin
      if (rst || (r_state == ST_FLUSH)) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_fill      <= '0;
         r_frame_cnt <= '0;
         r_in_frame  <= 1'b0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);

         case ({w_wr_en, w_pop})
            2'b10:   r_fill <= r_fill + LVL_W'(1);
            2'b01:   r_fill <= r_fill - LVL_W'(1);
            default: r_fill <= r_fill;
         endcase

         case ({w_wr_last, w_pop_last})
            2'b10:   r_frame_cnt <= r_frame_cnt + LVL_W'(1);
            2'b01:   r_frame_cnt <= r_frame_cnt - LVL_W'(1);
            default: r_frame_cnt <= r_frame_cnt;
         endcase

         if (w_pop) r_in_frame <= ~w_rd_entry[DATA_W];
      end
   end

   // Output strobe towards data_controller; data holds between strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         axi_valid <= 1'b0;
         axi_last  <= 1'b0;
         axi_data  <= '0;
         underrun  <= 1'b0;
      end else begin
         axi_valid <= w_pop;
         axi_last  <= w_pop_last;
         if (w_pop) axi_data <= w_rd_entry[DATA_W-1:0];
         underrun  <= w_run && r_in_frame && tx_ready && w_empty;
      end
   end

endmodule

// File: tb/tb_aurora_tx_frame_buffer.sv
// Directed bench for aurora_tx_frame_buffer: link gating, store-and-forward,
// tx_ready pacing, full-FIFO cut-through with underrun, back-to-back frames,
// link drop flush and mid-frame reset.
module tb_aurora_tx_frame_buffer;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int LVL_W  = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cif = 1'b0;
   logic              s_tvalid = 1'b0;
   logic              s_tready;
   logic              s_tlast = 1'b0;
   logic [DATA_W-1:0] s_tdata = '0;
   logic              tx_ready = 1'b0;
   logic              axi_valid;
   logic              axi_last;
   logic [DATA_W-1:0] axi_data;
   logic [LVL_W-1:0]  fill_level;
   logic              underrun;

   int n_assert = 0;
   int n_fail   = 0;

   aurora_tx_frame_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .channel_init_finished (cif),
      .s_axis_tvalid         (s_tvalid),
      .s_axis_tready         (s_tready),
      .s_axis_tlast          (s_tlast),
      .s_axis_tdata          (s_tdata),
      .tx_ready              (tx_ready),
      .axi_valid             (axi_valid),
      .axi_last              (axi_last),
      .axi_data              (axi_data),
      .fill_level            (fill_level),
      .underrun              (underrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input logic l);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
   endtask

   task automatic idle();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One line per transaction: valid/last/data/fill/underrun compared in one go.
   task automatic expect_out(input string tag, input logic v, input logic l,
                             input logic [DATA_W-1:0] d, input logic [LVL_W-1:0] f,
                             input logic u);
      check(tag, {underrun, fill_level, axi_valid, axi_last, axi_data},
                 {u, f, v, l, d});
      $display("%0t %s valid=%0b last=%0b data=%08h fill=%0d underrun=%0b",
               $time, tag, axi_valid, axi_last, axi_data, fill_level, underrun);
   endtask

   initial begin
      // Reset
      tick();
      tick();
      check("rst_tready", s_tready, 1'b0);
      expect_out("rst", 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      rst = 1'b0;

      // 1: link down blocks everything
      send(32'hDEAD_BEEF, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t1_tready", s_tready, 1'b0);
         expect_out("t1_out", 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      end

      // 2: link up, 4-word frame store-and-forward
      idle();
      cif = 1'b1;
      tick();
      check("t2_tready_up", s_tready, 1'b1);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(32'hA000_0000 + 32'(i), i == 3);
         tick();
         expect_out("t2_hold", 1'b0, 1'b0, 32'h0, 5'(i + 1), 1'b0);
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_out("t2_out", 1'b1, i == 3, 32'hA000_0000 + 32'(i), 5'(3 - i), 1'b0);
      end
      tick();
      expect_out("t2_end", 1'b0, 1'b0, 32'hA000_0003, 5'd0, 1'b0);

      // 3: tx_ready pacing during a 3-word frame
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(32'hB000_0000 + 32'(i), i == 2);
         tick();
         expect_out("t3_load", 1'b0, 1'b0, 32'hA000_0003, 5'(i + 1), 1'b0);
      end
      idle();
      tx_ready = 1'b1; tick(); expect_out("t3_p0", 1'b1, 1'b0, 32'hB000_0000, 5'd2, 1'b0);
      tx_ready = 1'b0; tick(); expect_out("t3_s0", 1'b0, 1'b0, 32'hB000_0000, 5'd2, 1'b0);
      tx_ready = 1'b1; tick(); expect_out("t3_p1", 1'b1, 1'b0, 32'hB000_0001, 5'd1, 1'b0);
      tx_ready = 1'b0; tick(); expect_out("t3_s1", 1'b0, 1'b0, 32'hB000_0001, 5'd1, 1'b0);
      tx_ready = 1'b1; tick(); expect_out("t3_p2", 1'b1, 1'b1, 32'hB000_0002, 5'd0, 1'b0);
      tx_ready = 1'b0; tick(); expect_out("t3_s2", 1'b0, 1'b0, 32'hB000_0002, 5'd0, 1'b0);

      // 4a: 20-word frame fills FIFO, cut-through completes it
      for (int i = 0; i < 16; i++) begin
         send(32'hC000_0000 + 32'(i), 1'b0);
         tick();
         expect_out("t4_load", 1'b0, 1'b0, 32'hB000_0002, 5'(i + 1), 1'b0);
      end
      check("t4_full_tready", s_tready, 1'b0);
      send(32'hC000_0010, 1'b0);
      tick();
      check("t4_full_hold_tready", s_tready, 1'b0);
      expect_out("t4_full_hold", 1'b0, 1'b0, 32'hB000_0002, 5'd16, 1'b0);
      tx_ready = 1'b1;
      tick();
      check("t4_tready_back", s_tready, 1'b1);
      expect_out("t4_ct0", 1'b1, 1'b0, 32'hC000_0000, 5'd15, 1'b0);
      tick(); expect_out("t4_ct1", 1'b1, 1'b0, 32'hC000_0001, 5'd15, 1'b0);
      send(32'hC000_0011, 1'b0);
      tick(); expect_out("t4_ct2", 1'b1, 1'b0, 32'hC000_0002, 5'd15, 1'b0);
      send(32'hC000_0012, 1'b0);
      tick(); expect_out("t4_ct3", 1'b1, 1'b0, 32'hC000_0003, 5'd15, 1'b0);
      send(32'hC000_0013, 1'b1);
      tick(); expect_out("t4_ct4", 1'b1, 1'b0, 32'hC000_0004, 5'd15, 1'b0);
      idle();
      for (int j = 5; j < 20; j++) begin
         tick();
         expect_out("t4_drain", 1'b1, j == 19, 32'hC000_0000 + 32'(j), 5'(19 - j), 1'b0);
      end
      tick();
      expect_out("t4_end", 1'b0, 1'b0, 32'hC000_0013, 5'd0, 1'b0);

      // 4b: cut-through with input stall -> underrun
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         send(32'hD000_0000 + 32'(i), 1'b0);
         tick();
      end
      check("t4b_fill", fill_level, 5'd16);
      idle();
      tx_ready = 1'b1;
      for (int j = 0; j < 16; j++) begin
         tick();
         expect_out("t4b_drain", 1'b1, 1'b0, 32'hD000_0000 + 32'(j), 5'(15 - j), 1'b0);
      end
      tick();
      expect_out("t4b_underrun", 1'b0, 1'b0, 32'hD000_000F, 5'd0, 1'b1);
      send(32'hD000_0010, 1'b0);
      tick();
      expect_out("t4b_refill", 1'b0, 1'b0, 32'hD000_000F, 5'd1, 1'b1);
      send(32'hD000_0011, 1'b1);
      tick();
      expect_out("t4b_resume", 1'b1, 1'b0, 32'hD000_0010, 5'd1, 1'b0);
      idle();
      tick();
      expect_out("t4b_last", 1'b1, 1'b1, 32'hD000_0011, 5'd0, 1'b0);
      tick();
      expect_out("t4b_end", 1'b0, 1'b0, 32'hD000_0011, 5'd0, 1'b0);

      // 5a: frame of 1 then frame of 3 with simultaneous write/pop
      send(32'hE000_0000, 1'b1);
      tick(); expect_out("t5_e0_in", 1'b0, 1'b0, 32'hD000_0011, 5'd1, 1'b0);
      send(32'hF000_0000, 1'b0);
      tick(); expect_out("t5_e0_out", 1'b1, 1'b1, 32'hE000_0000, 5'd1, 1'b0);
      send(32'hF000_0001, 1'b0);
      tick(); expect_out("t5_f1_in", 1'b0, 1'b0, 32'hE000_0000, 5'd2, 1'b0);
      send(32'hF000_0002, 1'b1);
      tick(); expect_out("t5_f2_in", 1'b0, 1'b0, 32'hE000_0000, 5'd3, 1'b0);
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("t5_f_out", 1'b1, i == 2, 32'hF000_0000 + 32'(i), 5'(2 - i), 1'b0);
      end

      // 5b: two queued frames leave with no gap between them
      tx_ready = 1'b0;
      send(32'h6000_0000, 1'b1); tick();
      send(32'h7000_0000, 1'b0); tick();
      send(32'h7000_0001, 1'b0); tick();
      send(32'h7000_0002, 1'b1); tick();
      idle();
      check("t5b_fill", fill_level, 5'd4);
      tx_ready = 1'b1;
      tick(); expect_out("t5b_g0", 1'b1, 1'b1, 32'h6000_0000, 5'd3, 1'b0);
      tick(); expect_out("t5b_h0", 1'b1, 1'b0, 32'h7000_0000, 5'd2, 1'b0);
      tick(); expect_out("t5b_h1", 1'b1, 1'b0, 32'h7000_0001, 5'd1, 1'b0);
      tick(); expect_out("t5b_h2", 1'b1, 1'b1, 32'h7000_0002, 5'd0, 1'b0);
      tick(); expect_out("t5b_end", 1'b0, 1'b0, 32'h7000_0002, 5'd0, 1'b0);

      // 6a: link drop with 5 words of an incomplete frame stored
      for (int i = 0; i < 5; i++) begin
         send(32'h9000_0000 + 32'(i), 1'b0);
         tick();
         expect_out("t6_load", 1'b0, 1'b0, 32'h7000_0002, 5'(i + 1), 1'b0);
      end
      idle();
      cif = 1'b0;
      tick();
      check("t6_flush_tready", s_tready, 1'b0);
      expect_out("t6_flush", 1'b0, 1'b0, 32'h7000_0002, 5'd5, 1'b0);
      tick();
      check("t6_init_tready", s_tready, 1'b0);
      expect_out("t6_cleared", 1'b0, 1'b0, 32'h7000_0002, 5'd0, 1'b0);
      cif = 1'b1;
      tick();
      check("t6_relink_tready", s_tready, 1'b1);
      send(32'h5000_0000, 1'b0); tick();
      send(32'h5000_0001, 1'b1); tick();
      expect_out("t6_k_in", 1'b0, 1'b0, 32'h7000_0002, 5'd2, 1'b0);
      idle();
      tick(); expect_out("t6_k0", 1'b1, 1'b0, 32'h5000_0000, 5'd1, 1'b0);
      tick(); expect_out("t6_k1", 1'b1, 1'b1, 32'h5000_0001, 5'd0, 1'b0);

      // 6b: reset mid-frame with a concurrent write and pop
      send(32'h3000_0000, 1'b0); tick();
      send(32'h3000_0001, 1'b0); tick();
      send(32'h3000_0002, 1'b1); tick();
      idle();
      tick();
      expect_out("t6b_l0", 1'b1, 1'b0, 32'h3000_0000, 5'd2, 1'b0);
      rst = 1'b1;
      send(32'h4000_0000, 1'b0);
      tick();
      check("t6b_rst_tready", s_tready, 1'b0);
      expect_out("t6b_rst", 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      rst = 1'b0;
      idle();
      tick();
      check("t6b_run_tready", s_tready, 1'b1);
      expect_out("t6b_after", 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
